// File: rtl/alu_mul_seq.sv
// Sequential 6x6 unsigned shift-and-add multiplier built around one shared RCA6.
// Operands and product each move through a valid/ready handshake.

module rca6 (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [5:0] sum,
    output logic       c
);
    localparam int unsigned W = 6;

    logic [W:0] cy;

    assign cy[0] = cin;

    // Plain ripple chain of full adders.
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign c = cy[W];
endmodule

module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] product,
    output logic        busy
);
    localparam int unsigned W     = 6;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     mcand;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sum;
    logic             c;

    // Single adder, reused every iteration: partial product plus multiplicand.
    rca6 u_rca6 (
        .a   (hi),
        .b   (mcand),
        .cin (1'b0),
        .sum (sum),
        .c   (c)
    );

    // Handshake flags are kept as flops that track the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        hi       <= '0;
                        lo       <= b;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Carry-out becomes the new MSB of the shifted partial product.
                    if (lo[0]) begin
                        {hi, lo} <= {c, sum, lo[W-1:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[W-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign product = {hi, lo};
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential 6×6 unsigned shift-and-add multiplier for the Simple ALU. It time-multiplexes one internal instance of the 6-bit ripple-carry adder, RCA6, over six iterations to produce a 12-bit product. Operands enter through a valid/ready handshake and the result leaves through one, so the block sits as the MUL functional unit beside the ALU's add/sub path.

## Interface
Parameters: none. Width is fixed at 6 bits to match RCA6.

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b are valid this cycle
- in_ready  output  1  block can accept operands; equals (state == IDLE)
- a  input  6  multiplicand, unsigned
- b  input  6  multiplier, unsigned
- out_valid  output  1  product holds a completed result; equals (state == DONE)
- out_ready  input  1  consumer accepts the product this cycle
- product  output  12  registered result {hi, lo}
- busy  output  1  high in RUN (and DONE); low only in IDLE

## Operation
- Internal registers:
  - mcand[5:0]: latched a
  - hi[5:0], lo[5:0]: product register, with lo initially holding b
  - cnt[2:0]: iteration count
  - state: IDLE / RUN / DONE
- RCA6 is instantiated once with A = hi, B = mcand, in = 1'b0. Its carry-out c and sum[5:0] are used combinationally.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: load mcand ← a, hi ← 0, lo ← b, cnt ← 0, then go to RUN.
  - Otherwise hold every register, including the last product.
- RUN, one iteration per edge:
  - If lo[0] = 1: {hi, lo} ← {c, sum, lo[5:1]}.
  - Else: {hi, lo} ← {1'b0, hi, lo[5:1]}.
  - cnt ← cnt + 1.
  - On the edge where cnt == 5 (the 6th iteration), go to DONE.
- DONE:
  - product is stable.
  - On an edge with out_ready = 1, go to IDLE.
  - in_valid is ignored while in RUN or DONE.
- Arithmetic:
  - The product always fits in 12 bits (max 63·63 = 3969 = 0xF81), so there is no overflow flag.
  - Latency is fixed and independent of operand values; there is no early termination on zero operands.
- product = {hi, lo}. It is visible in every state but meaningful only while out_valid = 1.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk):
  - state = IDLE, hi = lo = mcand = 0, cnt = 0.
  - Outputs: product = 0x000, out_valid = 0, busy = 0, in_ready = 1.
- Latency:
  - Call the accepting edge E0, where in_valid && in_ready.
  - Iterations occur on edges E1–E6.
  - out_valid = 1 and busy = 1 after E6.
- Throughput:
  - The earliest next acceptance is the edge after the out_ready handshake edge, since in_ready rises only once the block is back in IDLE.
  - Minimum initiation interval is 8 cycles: accept, six iterations, one DONE cycle.
- Backpressure: while out_ready = 0 in DONE, out_valid, product and busy hold indefinitely.
- Output handshake: out_valid and out_ready are sampled on the same edge; the transfer completes on that edge.
- Reset mid-operation: asserting rst in RUN or DONE aborts the operation. The result is lost, with no partial out_valid pulse.
- cnt never wraps in normal operation; it is reloaded on every acceptance.

## Test plan
- Reset state: assert rst asynchronously between edges -> product = 0x000, out_valid = 0, in_ready = 1, busy = 0 immediately.
- Maximum operands: a = 0x3F, b = 0x3F, out_ready = 1 -> out_valid after exactly 6 edges past acceptance, product = 0xF81, IDLE one edge later.
- Directed operands (latency fixed at 6 for each):
  - a = 0x25, b = 0x1B -> 0x3E7
  - a = 0x01, b = 0x2A -> 0x02A
  - a = 0x00, b = 0x3F -> 0x000
  - a = 0x3F, b = 0x00 -> 0x000
- Backpressure: a = 0x3F, b = 0x3F with out_ready held 0 for 5 cycles after out_valid, while in_valid toggles with other operands -> product stays 0xF81, in_ready stays 0, no new operands accepted. Raising out_ready completes the transfer.
- Reset mid-operation: a = 0x25, b = 0x1B, assert rst after E3 -> immediate IDLE, product = 0. Then 0x3F × 0x02 completes normally with product = 0x07E.
- Back-to-back: in_valid held 1 with two operand pairs and out_ready = 1 -> second acceptance occurs exactly 8 edges after the first. Both products are correct, and each result's out_valid is exactly one cycle wide.
